// File: rtl/alu_arbiter_r32i.sv
// Round-robin arbiter sharing one RV32I ALU between two requesters.
// Optional illegal-alucode check: define ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter_r32i #(
    parameter int dataW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*dataW-1:0] req_a,
    input  logic [2*dataW-1:0] req_b,
    input  logic [7:0]         req_alucode,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [dataW-1:0]   resp_result,
    output logic               resp_err,
    output logic [dataW-1:0]   alu_a,
    output logic [dataW-1:0]   alu_b,
    output logic [3:0]         alu_code,
    input  logic [dataW-1:0]   alu_result
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] ADD = 4'd0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    localparam logic [3:0] SUB = 4'd10;
`endif

    state_t            state_q, state_d;
    logic [dataW-1:0]  alu_a_q, alu_a_d;
    logic [dataW-1:0]  alu_b_q, alu_b_d;
    logic [3:0]        alu_code_q, alu_code_d;
    logic [dataW-1:0]  resp_result_q, resp_result_d;
    logic              owner_q, owner_d;
    logic              rr_last_q, rr_last_d;
    logic              gnt;
    logic [dataW-1:0]  sel_a;
    logic [dataW-1:0]  sel_b;
    logic [3:0]        sel_code;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic              resp_err_q, resp_err_d;
`endif

    // Round-robin pick: on a tie the requester that did not win last time.
    always_comb begin
        gnt      = req_valid[1];
        if (&req_valid) begin
            gnt = ~rr_last_q;
        end
        sel_a    = gnt ? req_a[2*dataW-1:dataW] : req_a[dataW-1:0];
        sel_b    = gnt ? req_b[2*dataW-1:dataW] : req_b[dataW-1:0];
        sel_code = gnt ? req_alucode[7:4] : req_alucode[3:0];
    end

    // Next-state and handshake outputs of the IDLE/EXEC/RESP controller.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_code_d    = alu_code_q;
        resp_result_d = resp_result_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        req_ready     = 2'b00;
        resp_valid    = 2'b00;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        resp_err_d    = resp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = gnt ? 2'b10 : 2'b01;
                    owner_d   = gnt;
                    rr_last_d = gnt;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    if (sel_code > SUB) begin
                        resp_result_d = '0;
                        resp_err_d    = 1'b1;
                        state_d       = RESP;
                    end else begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_code_d = sel_code;
                        state_d    = EXEC;
                    end
`else
                    alu_a_d    = sel_a;
                    alu_b_d    = sel_b;
                    alu_code_d = sel_code;
                    state_d    = EXEC;
`endif
                end
            end
            EXEC: begin
                resp_result_d = alu_result;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                resp_err_d    = 1'b0;
`endif
                state_d       = RESP;
            end
            RESP: begin
                resp_valid = owner_q ? 2'b10 : 2'b01;
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and ALU-boundary registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_code_q    <= ADD;
            resp_result_q <= '0;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_code_q    <= alu_code_d;
            resp_result_q <= resp_result_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    // Error flag travels with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_code    = alu_code_q;
    assign resp_result = resp_result_q;

endmodule

// File: tb/tb_alu_arbiter_r32i.sv
// Directed bench for alu_arbiter_r32i with a behavioural stand-in ALU.
// Honours ALU_ARB_ILLEGAL_CHK_EN for the illegal-alucode case.
module tb_alu_arbiter_r32i;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SLL  = 4'd1;
    localparam logic [3:0] C_SLT  = 4'd2;
    localparam logic [3:0] C_SLTU = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_SRL  = 4'd5;
    localparam logic [3:0] C_SRA  = 4'd6;
    localparam logic [3:0] C_OR   = 4'd7;
    localparam logic [3:0] C_AND  = 4'd8;
    localparam logic [3:0] C_LUI  = 4'd9;
    localparam logic [3:0] C_SUB  = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_alucode;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;
    logic        resp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_code;
    logic [31:0] alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter_r32i #(.dataW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_alucode (req_alucode),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_code    (alu_code),
        .alu_result  (alu_result)
    );

    // Stand-in for the aluR32I instance.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_code)
            C_ADD:  alu_result = alu_a + alu_b;
            C_SLL:  alu_result = alu_a << alu_b[4:0];
            C_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            C_SLTU: alu_result = {31'd0, alu_a < alu_b};
            C_XOR:  alu_result = alu_a ^ alu_b;
            C_SRL:  alu_result = alu_a >> alu_b[4:0];
            C_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            C_OR:   alu_result = alu_a | alu_b;
            C_AND:  alu_result = alu_a & alu_b;
            C_LUI:  alu_result = alu_b;
            C_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        int          rq;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  code;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int rq, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
        if (rq == 1) begin
            req_a[63:32]     = a;
            req_b[63:32]     = b;
            req_alucode[7:4] = c;
        end else begin
            req_a[31:0]      = a;
            req_b[31:0]      = b;
            req_alucode[3:0] = c;
        end
    endtask

    task automatic run_op(input int rq, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] c,
                          input logic [31:0] exp, input logic err,
                          input bit fast, input string nm);
        logic [1:0] oh;
        oh = (rq == 1) ? 2'b10 : 2'b01;
        drive(rq, a, b, c);
        req_valid  = oh;
        resp_ready = oh;
        #1;
        chk({nm, "_ready"}, {62'd0, req_ready}, {62'd0, oh});
        tick();
        req_valid = 2'b00;
        if (!fast) begin
            chk({nm, "_exec_rv"}, {62'd0, resp_valid}, 64'd0);
            tick();
        end
        chk({nm, "_rv"}, {62'd0, resp_valid}, {62'd0, oh});
        chk({nm, "_res"}, {32'd0, resp_result}, {32'd0, exp});
        chk({nm, "_err"}, {63'd0, resp_err}, {63'd0, err});
        tick();
        chk({nm, "_idle_rv"}, {62'd0, resp_valid}, 64'd0);
        resp_ready = 2'b00;
    endtask

    initial begin
        bit fast_ill;
        logic [31:0] ill_exp;
        logic        ill_err;

        tbl[0] = '{0, 32'd5, 32'd7, C_ADD, 32'd12, "add"};
        tbl[1] = '{0, 32'd10, 32'd3, C_SUB, 32'd7, "sub"};
        tbl[2] = '{1, 32'hF0, 32'hFF, C_XOR, 32'h0F, "xor"};
        tbl[3] = '{1, 32'hFFFFFFFF, 32'd1, C_SLT, 32'd1, "slt"};
        tbl[4] = '{0, 32'hFFFFFFFF, 32'd1, C_SLTU, 32'd0, "sltu"};
        tbl[5] = '{0, 32'd1, 32'd31, C_SLL, 32'h80000000, "sll"};
        tbl[6] = '{1, 32'h80000000, 32'd4, C_SRA, 32'hF8000000, "sra"};
        tbl[7] = '{1, 32'h80000000, 32'd4, C_SRL, 32'h08000000, "srl"};
        tbl[8] = '{0, 32'hF0F0, 32'hFF00, C_AND, 32'hF000, "and"};
        tbl[9] = '{1, 32'hF0F0, 32'h0F0F, C_OR, 32'hFFFF, "or"};

        req_a       = '0;
        req_b       = '0;
        req_alucode = '0;
        do_reset();

        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rv", {62'd0, resp_valid}, 64'd0);
        chk("rst_res", {32'd0, resp_result}, 64'd0);
        chk("rst_err", {63'd0, resp_err}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_alu_code", {60'd0, alu_code}, 64'd0);

        for (int k = 0; k < 10; k++) begin
            run_op(tbl[k].rq, tbl[k].a, tbl[k].b, tbl[k].code,
                   tbl[k].exp, 1'b0, 1'b0, tbl[k].name);
        end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
        fast_ill = 1'b1;
        ill_exp  = 32'd0;
        ill_err  = 1'b1;
`else
        fast_ill = 1'b0;
        ill_exp  = 32'hDEADBEEF;
        ill_err  = 1'b0;
`endif
        run_op(0, 32'd3, 32'd4, 4'd15, ill_exp, ill_err, fast_ill, "ill15");
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        chk("ill_alu_a_kept", {32'd0, alu_a}, 64'h0000F0F0);
        chk("ill_alu_code_kept", {60'd0, alu_code}, {60'd0, C_OR});
`endif

        // Both requesters valid every cycle: grants alternate from 0.
        do_reset();
        req_a       = {32'hF0, 32'd10};
        req_b       = {32'hFF, 32'd3};
        req_alucode = {C_XOR, C_SUB};
        resp_ready  = 2'b11;
        req_valid   = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  oh;
            logic [31:0] ex;
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            ex = (k % 2 == 1) ? 32'h0F : 32'd7;
            chk($sformatf("rr_gnt%0d", k), {62'd0, req_ready}, {62'd0, oh});
            tick();
            tick();
            chk($sformatf("rr_rv%0d", k), {62'd0, resp_valid}, {62'd0, oh});
            chk($sformatf("rr_res%0d", k), {32'd0, resp_result}, {32'd0, ex});
            tick();
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;

        // Back-pressure on requester 1 while requester 0 waits.
        do_reset();
        drive(1, 32'hFFFFFFFF, 32'd1, C_SLT);
        req_valid = 2'b10;
        #1;
        chk("bp_gnt1", {62'd0, req_ready}, 64'd2);
        tick();
        drive(0, 32'd2, 32'd3, C_ADD);
        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_rv%0d", k), {62'd0, resp_valid}, 64'd2);
            chk($sformatf("bp_res%0d", k), {32'd0, resp_result}, 64'd1);
            chk($sformatf("bp_rdy%0d", k), {62'd0, req_ready}, 64'd0);
            tick();
        end
        resp_ready = 2'b10;
        tick();
        chk("bp_gnt0", {62'd0, req_ready}, 64'd1);
        resp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("bp_res0", {32'd0, resp_result}, 64'd5);
        chk("bp_rv0", {62'd0, resp_valid}, 64'd1);
        tick();
        resp_ready = 2'b00;

        // Non-owner resp_ready does not release RESP.
        drive(0, 32'd20, 32'd22, C_ADD);
        req_valid = 2'b01;
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b10;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("no_rv%0d", k), {62'd0, resp_valid}, 64'd1);
            tick();
        end
        chk("no_res", {32'd0, resp_result}, 64'd42);
        resp_ready = 2'b01;
        tick();
        chk("no_idle", {62'd0, resp_valid}, 64'd0);
        resp_ready = 2'b00;

        // Reset while an operation sits in EXEC.
        drive(0, 32'd1, 32'd31, C_SLL);
        req_valid  = 2'b01;
        resp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();
        chk("ab_ready", {62'd0, req_ready}, 64'd0);
        chk("ab_rv", {62'd0, resp_valid}, 64'd0);
        chk("ab_res", {32'd0, resp_result}, 64'd0);
        chk("ab_alu_a", {32'd0, alu_a}, 64'd0);
        chk("ab_alu_b", {32'd0, alu_b}, 64'd0);
        chk("ab_alu_code", {60'd0, alu_code}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("ab_quiet%0d", k), {62'd0, resp_valid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
